batch_ctrl_pp: RTL

BATCH_CTRL_PP -- requirements
Module: batch_ctrl_pp

---
 rtl/batch_ctrl_pp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/batch_ctrl_pp.sv
// rtl/batch_ctrl_pp.sv - round-robin multi-bank batch fill / compute / drain controller
// Optional src_last checking enabled by defining BATCH_CTRL_PP_LAST_CHK_EN.
module batch_ctrl_pp #(
  parameter int AW    = 12,
  parameter int NBANK = 2,
  localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          src_valid,
  input  logic          src_last,
  output logic          src_ready,
  output logic          src_v,
  output logic [AW-1:0] src_a,
  output logic [BW-1:0] src_bank,
  output logic          s_init,
  output logic [BW-1:0] s_bank,
  input  logic          s_fin,
  output logic          dst_valid,
  input  logic          dst_ready,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  input  logic [AW-1:0] ss,
  input  logic [AW-1:0] ds,
  output logic          err_last
);

  logic [AW-1:0]    src_a_q, src_a_d;
  logic [AW-1:0]    dst_a_q, dst_a_d;
  logic [BW-1:0]    wb_q, wb_d;
  logic [BW-1:0]    rb_q, rb_d;
  logic [NBANK-1:0] full_q, full_d;
  logic             busy_q, busy_d;
  logic             s_init_q, s_init_d;
  logic [BW-1:0]    s_bank_q, s_bank_d;
  logic             dst_valid_q, dst_valid_d;
  logic             err_last_q, err_last_d;
  logic             src_at_end;
  logic             fill_last;

  // rst_n gates src_ready so every output reads 0 while reset is held
  assign src_ready = run & rst_n & ~full_q[wb_q];
  assign src_v     = run & src_valid & src_ready;
  assign src_a     = src_a_q;
  assign src_bank  = wb_q;
  assign s_init    = s_init_q;
  assign s_bank    = s_bank_q;
  assign dst_valid = dst_valid_q;
  assign dst_v     = dst_valid_q & dst_ready;
  assign dst_a     = dst_a_q;
  assign err_last  = err_last_q;

  assign src_at_end = (src_a_q == ss);
  assign fill_last  = src_v & src_at_end;

`ifndef BATCH_CTRL_PP_LAST_CHK_EN
  logic unused_src_last;
  assign unused_src_last = src_last;
`endif

  always_comb begin
    src_a_d     = src_a_q;
    dst_a_d     = dst_a_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    full_d      = full_q;
    busy_d      = busy_q;
    s_init_d    = 1'b0;
    s_bank_d    = s_bank_q;
    dst_valid_d = dst_valid_q;
    err_last_d  = err_last_q;
    if (!run) begin
      src_a_d     = '0;
      dst_a_d     = '0;
      wb_d        = '0;
      rb_d        = '0;
      full_d      = '0;
      busy_d      = 1'b0;
      s_bank_d    = '0;
      dst_valid_d = 1'b0;
      err_last_d  = 1'b0;
    end else begin
      if (src_v) begin
        if (src_at_end) begin
          src_a_d = '0;
          wb_d    = wb_q + 1'b1;
        end else begin
          src_a_d = src_a_q + 1'b1;
        end
      end
      // release happens before the fill set so a same-cycle fill of another bank survives
      if (s_fin && busy_q && !dst_valid_q) begin
        full_d[rb_q] = 1'b0;
        rb_d         = rb_q + 1'b1;
        dst_valid_d  = 1'b1;
        dst_a_d      = '0;
      end
      if (fill_last) begin
        full_d[wb_q] = 1'b1;
      end
      if (dst_v) begin
        if (dst_a_q == ds) begin
          dst_valid_d = 1'b0;
          dst_a_d     = '0;
          busy_d      = 1'b0;
        end else begin
          dst_a_d = dst_a_q + 1'b1;
        end
      end
      // look at the bank's next full state so compute starts the cycle after its last beat
      if (!busy_q && !s_init_q && (full_q[rb_q] || (fill_last && (wb_q == rb_q)))) begin
        s_init_d = 1'b1;
        busy_d   = 1'b1;
        s_bank_d = rb_q;
      end
`ifdef BATCH_CTRL_PP_LAST_CHK_EN
      if (src_v && (src_last != src_at_end)) begin
        err_last_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_q     <= '0;
      dst_a_q     <= '0;
      wb_q        <= '0;
      rb_q        <= '0;
      full_q      <= '0;
      busy_q      <= 1'b0;
      s_init_q    <= 1'b0;
      s_bank_q    <= '0;
      dst_valid_q <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      src_a_q     <= src_a_d;
      dst_a_q     <= dst_a_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      busy_q      <= busy_d;
      s_init_q    <= s_init_d;
      s_bank_q    <= s_bank_d;
      dst_valid_q <= dst_valid_d;
      err_last_q  <= err_last_d;
    end
  end

endmodule
